// File: rtl/if_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pkg
//   Shared constants and helpers for the instruction-fetch stage.
//   RESET_PC        : address of the first fetch after reset
//   FS_TO_DS_BUS_WD : width of {inst, pc} handed to decode
//   BR_BUS_WD       : width of {br_taken, br_target} coming back from decode
// ----------------------------------------------------------------------------
package if_stage_pkg;

  localparam logic [31:0] RESET_PC        = 32'h1c00_0000;
  localparam int          FS_TO_DS_BUS_WD = 64;
  localparam int          BR_BUS_WD       = 33;
  localparam logic [31:0] INST_BYTES      = 32'd4;

  // Sequential successor of a fetch address; wraps modulo 2^32.
  function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage. Holds the PC, drives a synchronous instruction
//   SRAM with one cycle of read latency and hands {inst, pc} to decode over a
//   valid/allowin handshake. A branch redirect from decode squashes the
//   instruction currently in fetch and starts fetching the target at once.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   reset           : asynchronous, active-high
//   ds_allowin      : decode can accept an instruction this cycle
//   br_bus          : {br_taken, br_target}; br_taken is a one-cycle pulse
//   fs_to_ds_valid  : fs_to_ds_bus carries a valid instruction
//   fs_to_ds_bus    : {fs_inst, fs_pc}
//   inst_sram_en    : SRAM read enable
//   inst_sram_we    : SRAM write enable, always 0
//   inst_sram_addr  : SRAM address (next PC), driven even when en is low
//   inst_sram_wdata : SRAM write data, always 0
//   inst_sram_rdata : SRAM read data, valid the cycle after en
// ----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic                       inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  logic        br_taken_s;
  logic [31:0] br_target_s;
  logic        to_fs_valid_s;
  logic [31:0] seq_pc_s;
  logic [31:0] nextpc_s;
  logic        fs_ready_go_s;
  logic        fs_allowin_s;
  logic        fetch_s;
  logic        handover_s;
  logic        stall_s;
  logic [31:0] fs_inst_s;

  logic [31:0] fs_pc_r;
  logic        fs_valid_r;
  logic        buf_valid_r;
  logic [31:0] buf_inst_r;

  assign br_taken_s  = br_bus[BR_BUS_WD-1];
  assign br_target_s = br_bus[31:0];

  // Pre-IF: next fetch address and the fetch-stage handshake terms.
  always_comb begin
    to_fs_valid_s = ~reset;
    seq_pc_s      = seq_next_pc(fs_pc_r);
    fs_ready_go_s = 1'b1;
    if (br_taken_s) begin
      nextpc_s = br_target_s;
    end else begin
      nextpc_s = seq_pc_s;
    end
    // A branch forces allowin so the redirect is fetched in the same cycle;
    // this is why no pending-redirect register is needed.
    fs_allowin_s = ~fs_valid_r | (fs_ready_go_s & ds_allowin) | br_taken_s;
    fetch_s      = to_fs_valid_s & fs_allowin_s;
    handover_s   = fs_valid_r & ~br_taken_s & ds_allowin;
    stall_s      = fs_valid_r & ~ds_allowin & ~br_taken_s;
  end

  // Instruction source: the buffer once a stall has captured the SRAM word.
  always_comb begin
    if (buf_valid_r) begin
      fs_inst_s = buf_inst_r;
    end else begin
      fs_inst_s = inst_sram_rdata;
    end
  end

  // Outputs toward decode and the instruction SRAM.
  always_comb begin
    fs_to_ds_valid  = fs_valid_r & ~br_taken_s;
    fs_to_ds_bus    = {fs_inst_s, fs_pc_r};
    inst_sram_en    = fetch_s;
    inst_sram_we    = 1'b0;
    inst_sram_addr  = nextpc_s;
    inst_sram_wdata = 32'h0000_0000;
  end

  // PC register and fetch-stage valid; advance only when a fetch is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_pc_r    <= RESET_ADDR - INST_BYTES;
      fs_valid_r <= 1'b0;
    end else if (fetch_s) begin
      fs_pc_r    <= nextpc_s;
      fs_valid_r <= 1'b1;
    end else begin
      fs_pc_r    <= fs_pc_r;
      fs_valid_r <= fs_valid_r;
    end
  end

  // One-entry instruction buffer: captures the SRAM word on the first stall
  // cycle because the SRAM output is not guaranteed to hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_r <= 1'b0;
      buf_inst_r  <= 32'h0000_0000;
    end else if (handover_s || br_taken_s) begin
      buf_valid_r <= 1'b0;
      buf_inst_r  <= buf_inst_r;
    end else if (stall_s && !buf_valid_r) begin
      buf_valid_r <= 1'b1;
      buf_inst_r  <= inst_sram_rdata;
    end else begin
      buf_valid_r <= buf_valid_r;
      buf_inst_r  <= buf_inst_r;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
//   Random and directed stimulus for if_stage. A behavioural model tracks the
//   architectural stream of instructions decode should receive; accepted
//   instructions are queued and compared by an independent monitor.
// ----------------------------------------------------------------------------
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        ds_allowin;
  logic        br_taken_d;
  logic [31:0] br_target_d;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int checks;
  int errors;

  logic [63:0] sb_q[$];

  // behavioural model state
  bit          model_valid;
  logic [31:0] model_pc;

  // per-cycle expectations handed to the monitor
  bit          mon_on;
  bit          exp_valid;
  bit          exp_en;
  logic [31:0] exp_addr;
  logic [63:0] exp_bus;

  assign br_bus = {br_taken_d, br_target_d};

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_bus          (br_bus),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_1234;
  endfunction

  // Synchronous SRAM; when not enabled the output is scrambled so a design
  // that relies on rdata holding during a stall is exposed.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the model (called at posedge+1).
  task automatic drive(input bit allow, input bit br, input logic [31:0] tgt);
    ds_allowin  = allow;
    br_taken_d  = br;
    br_target_d = tgt;
    exp_valid = model_valid && !br;
    exp_en    = br || !model_valid || allow;
    exp_addr  = br ? tgt : (model_valid ? model_pc + 32'd4 : model_pc);
    exp_bus   = {mem_word(model_pc), model_pc};
    if (br) begin
      model_pc    = tgt;
      model_valid = 1'b1;
    end else if (!model_valid) begin
      model_valid = 1'b1;
    end else if (allow) begin
      sb_q.push_back(exp_bus);
      model_pc = model_pc + 32'd4;
    end
    mon_on = 1'b1;
  endtask

  task automatic step(input bit allow, input bit br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    drive(allow, br, tgt);
  endtask

  task automatic check_in_reset();
    chk("rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    chk("rst_en",    {63'd0, inst_sram_en},   64'd0);
    chk("rst_addr",  {32'd0, inst_sram_addr}, {32'd0, RESET_PC});
  endtask

  task automatic release_reset();
    reset = 1'b0;
    sb_q.delete();
    model_valid = 1'b0;
    model_pc    = RESET_PC;
    drive(1'b1, 1'b0, 32'd0);
  endtask

  // Assert reset between edges mid-stream, hold, then restart.
  task automatic do_reset(input int hold);
    @(posedge clk);
    #1;
    mon_on     = 1'b0;
    br_taken_d = 1'b0;
    reset      = 1'b1;
    #1;
    check_in_reset();
    repeat (hold) @(posedge clk);
    #1;
    release_reset();
  endtask

  // Monitor: per-cycle output checks plus scoreboard pops on handover.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on && !reset) begin
        chk("valid", {63'd0, fs_to_ds_valid}, {63'd0, exp_valid});
        chk("en",    {63'd0, inst_sram_en},   {63'd0, exp_en});
        chk("addr",  {32'd0, inst_sram_addr}, {32'd0, exp_addr});
        chk("we_wdata", {31'd0, inst_sram_we, inst_sram_wdata}, 64'd0);
        if (exp_valid) chk("bus", fs_to_ds_bus, exp_bus);
        if (fs_to_ds_valid && ds_allowin) begin
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'd0, 64'd1);
          end else begin
            chk("handover", fs_to_ds_bus, sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    mon_on      = 1'b0;
    model_valid = 1'b0;
    model_pc    = RESET_PC;
    ds_allowin  = 1'b0;
    br_taken_d  = 1'b0;
    br_target_d = 32'd0;
    reset       = 1'b0;
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_in_reset();
    @(posedge clk);
    #1;
    release_reset();

    // sequential fetch, stall with scrambled rdata, then accept
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    // branch while fs holds an instruction
    step(1'b1, 1'b1, 32'h1c00_0100);
    step(1'b1, 1'b0, 32'd0);
    // branch while stalled with a full buffer
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h1c00_0200);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    // sequential PC wraps past 2^32
    step(1'b1, 1'b1, 32'hffff_fff8);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    do_reset(2);

    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        step($urandom_range(0, 3) != 0,
             $urandom_range(0, 9) == 0,
             RESET_PC + ({22'd0, 10'($urandom_range(0, 1023))} << 2));
      end
    end

    @(negedge clk);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
